hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL provide parameter FWD_DEPTH, default 3, meaning number of tracked post-issue stages for forwarding (1..4).
REQ-002 SHALL provide parameter MAX_LD, default 4, meaning maximum outstanding loads (1..15).
REQ-003 SHALL provide parameter CNT_W, default 32, meaning width of the stall performance counter.
REQ-004 SHALL use one clock and a synchronous active-high reset: clk  in  1  clock, all state on rising edge; rst  in  1  synchronous active-high reset.
REQ-005 SHALL provide d_valid  in  1  D-stage holds a valid instruction.
REQ-006 SHALL provide d_rs1, d_rs2, d_rd  in  5 each  D-stage register indices.
REQ-007 SHALL provide d_use_rs1, d_use_rs2, d_wr_rd, d_is_load  in  1 each  D-stage operand-use, writes-rd, is-load flags.
REQ-008 SHALL provide redirect  in  1  taken branch/jump resolved in E; D instruction is squashed.
REQ-009 SHALL provide hold  in  1  external pipeline freeze (memory not ready).
REQ-010 SHALL provide ld_done  in  1, ld_rd  in  5  load data returned for register ld_rd this cycle.
REQ-011 SHALL provide issue  out  1  D instruction advances to E this cycle.
REQ-012 SHALL provide stall  out  1  D held due to hazard.
REQ-013 SHALL provide rs1_fwd_sel, rs2_fwd_sel  out  $clog2(FWD_DEPTH+1)  0 = register file, k = slot k-1.
REQ-014 SHALL provide ld_outstanding  out  4  current outstanding load count.
REQ-015 SHALL provide err  out  1  sticky: ld_done for non-pending register.
REQ-016 SHALL provide stall_cnt  out  CNT_W  cycles with stall=1, saturating.

Function
REQ-017 SHALL hold state: pend[31:0] bitmap, slot[0..FWD_DEPTH-1] each {valid, rd}, ld count, err, stall_cnt.
REQ-018 SHALL compute hz = d_valid & ((d_use_rs1 & d_rs1!=0 & pend[d_rs1]) | (d_use_rs2 & d_rs2!=0 & pend[d_rs2]) | (d_wr_rd & d_rd!=0 & pend[d_rd]) | (d_is_load & ld_outstanding==MAX_LD)), combinational.
REQ-019 SHALL drive stall = hz & !redirect & !hold; issue = d_valid & !hz & !redirect & !hold.
REQ-020 SHALL, when hold=0, shift slots each cycle: slot[i] <= slot[i-1]; slot[0] <= {issue & d_wr_rd & !d_is_load & d_rd!=0, d_rd}; when hold=1 slots freeze.
REQ-021 SHALL set rsN_fwd_sel = i+1 for the smallest i with slot[i].valid & slot[i].rd==d_rsN & d_rsN!=0 & d_use_rsN, else 0 (youngest wins).
REQ-022 SHALL, on issue & d_is_load & d_rd!=0, set pend[d_rd] and increment count next cycle.
REQ-023 SHALL, on ld_done & ld_rd!=0 & pend[ld_rd], clear pend[ld_rd] and decrement count; ld_done processed regardless of hold/redirect.
REQ-024 SHALL, on simultaneous load issue and ld_done to same rd, leave pend[rd]=1 and count unchanged (set wins).
REQ-025 SHALL, on simultaneous load issue and ld_done to different rd, set one bit, clear the other, count unchanged.
REQ-026 SHALL, on ld_done with pend[ld_rd]=0 or ld_rd=0, change no pend/count and set err=1 (except ld_rd=0: ignored, no err).
REQ-027 SHALL never let count exceed MAX_LD or go below 0.
REQ-028 SHALL increment stall_cnt when stall=1 and hold at 2^CNT_W-1.
REQ-029 SHALL squash D on redirect: issue=0, slots still shift with bubble in slot[0].

Reset
REQ-030 SHALL on rst=1 at a clock edge clear pend, all slot valids, count, err, stall_cnt; rst overrides all other inputs including ld_done.
REQ-031 SHALL drive issue, stall, fwd_sels combinationally from cleared state, so with d_valid=0 all outputs are 0 the cycle after reset.

Verification
REQ-032 SHALL cover: issue ADD x5 (d_wr_rd=1), next cycle D uses rs1=x5 -> rs1_fwd_sel=1; one cycle later -> 2; after FWD_DEPTH cycles -> 0.
REQ-033 SHALL cover: issue LW x7, D uses rs2=x7, ld_done x7 after 3 cycles -> stall=1 for 3 cycles, stall_cnt=3, issue=1 the cycle after ld_done.
REQ-034 SHALL cover: MAX_LD=4, issue 4 loads to x1..x4, 5th load to x6 -> stall=1, ld_outstanding=4; ld_done x1 -> 5th issues next cycle.
REQ-035 SHALL cover: pend[x9]=1, issue load x9 with ld_done x9 same cycle -> pend[x9]=1, count unchanged; ld_done x12 unpending -> err=1 sticky.
REQ-036 SHALL cover: hazard stall with redirect=1 -> stall=0, issue=0, slot[0] bubble; hold=1 -> slots and fwd_sel frozen, ld_done still clears pend.
REQ-037 SHALL cover: rst mid-operation with 2 loads outstanding -> ld_outstanding=0, pend=0, err=0, stall_cnt=0 next cycle.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Decode-stage hazard unit for an in-order pipeline. It tracks destination
//   registers of outstanding loads (a pending bitmap plus an outstanding count),
//   keeps a short shift history of recently issued ALU writers so that D-stage
//   operands can be forwarded, stalls D on load-use / write-after-load hazards
//   or a full load queue, and counts stall cycles.
//
// Ports
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_d_valid                     D holds a valid instruction
//   i_d_rs1/i_d_rs2/i_d_rd        D register indices
//   i_d_use_rs1/i_d_use_rs2       D reads rs1 / rs2
//   i_d_wr_rd, i_d_is_load        D writes rd / D is a load
//   i_redirect                    taken branch in E, D squashed
//   i_hold                        external pipeline freeze
//   i_ld_done, i_ld_rd            load data returned for register i_ld_rd
//   o_issue, o_stall              D advances / D held on a hazard
//   o_rs1_fwd_sel, o_rs2_fwd_sel  0 = register file, k = history slot k-1
//   o_ld_outstanding              outstanding load count
//   o_err                         sticky: load return for a non-pending register
//   o_stall_cnt                   saturating count of stall cycles
module hazard_scoreboard #(
  parameter int FWD_DEPTH = 3,
  parameter int MAX_LD    = 4,
  parameter int CNT_W     = 32,
  localparam int SEL_W    = $clog2(FWD_DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_d_valid,
  input  logic [4:0]       i_d_rs1,
  input  logic [4:0]       i_d_rs2,
  input  logic [4:0]       i_d_rd,
  input  logic             i_d_use_rs1,
  input  logic             i_d_use_rs2,
  input  logic             i_d_wr_rd,
  input  logic             i_d_is_load,
  input  logic             i_redirect,
  input  logic             i_hold,
  input  logic             i_ld_done,
  input  logic [4:0]       i_ld_rd,
  output logic             o_issue,
  output logic             o_stall,
  output logic [SEL_W-1:0] o_rs1_fwd_sel,
  output logic [SEL_W-1:0] o_rs2_fwd_sel,
  output logic [3:0]       o_ld_outstanding,
  output logic             o_err,
  output logic [CNT_W-1:0] o_stall_cnt
);

  logic [31:0]          r_pend;
  logic [FWD_DEPTH-1:0] r_slot_v;
  logic [4:0]           r_slot_rd [FWD_DEPTH];
  logic [3:0]           r_ld_cnt;
  logic                 r_err;
  logic [CNT_W-1:0]     r_stall_cnt;

  logic             w_rs1_haz;
  logic             w_rs2_haz;
  logic             w_rd_haz;
  logic             w_ld_full;
  logic             w_hz;
  logic             w_issue;
  logic             w_stall;
  logic             w_ld_set;
  logic             w_ld_clr;
  logic             w_ld_bad;
  logic [31:0]      w_pend_nxt;
  logic [SEL_W-1:0] w_rs1_sel;
  logic [SEL_W-1:0] w_rs2_sel;

  assign w_rs1_haz = i_d_use_rs1 && (i_d_rs1 != 5'd0) && r_pend[i_d_rs1];
  assign w_rs2_haz = i_d_use_rs2 && (i_d_rs2 != 5'd0) && r_pend[i_d_rs2];
  assign w_rd_haz  = i_d_wr_rd   && (i_d_rd  != 5'd0) && r_pend[i_d_rd];
  assign w_ld_full = i_d_is_load && (r_ld_cnt == 4'(MAX_LD));
  assign w_hz      = i_d_valid && (w_rs1_haz || w_rs2_haz || w_rd_haz || w_ld_full);
  assign w_stall   = w_hz && !i_redirect && !i_hold;
  assign w_issue   = i_d_valid && !w_hz && !i_redirect && !i_hold;

  // Load-return handling ignores hold/redirect: memory answers regardless.
  assign w_ld_set = w_issue && i_d_is_load && (i_d_rd != 5'd0);
  assign w_ld_clr = i_ld_done && (i_ld_rd != 5'd0) && r_pend[i_ld_rd];
  assign w_ld_bad = i_ld_done && (i_ld_rd != 5'd0) && !r_pend[i_ld_rd];

  // Set is applied after clear so a same-register issue/return keeps the bit.
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_ld_clr) w_pend_nxt[i_ld_rd] = 1'b0;
    if (w_ld_set) w_pend_nxt[i_d_rd]  = 1'b1;
  end

  // Scan oldest to youngest so the youngest matching slot wins.
  always_comb begin
    w_rs1_sel = '0;
    w_rs2_sel = '0;
    for (int i = FWD_DEPTH - 1; i >= 0; i--) begin
      if (r_slot_v[i] && (r_slot_rd[i] == i_d_rs1) && (i_d_rs1 != 5'd0) && i_d_use_rs1)
        w_rs1_sel = SEL_W'(i + 1);
      if (r_slot_v[i] && (r_slot_rd[i] == i_d_rs2) && (i_d_rs2 != 5'd0) && i_d_use_rs2)
        w_rs2_sel = SEL_W'(i + 1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pend      <= '0;
      r_slot_v    <= '0;
      for (int i = 0; i < FWD_DEPTH; i++) r_slot_rd[i] <= 5'd0;
      r_ld_cnt    <= 4'd0;
      r_err       <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      if (!i_hold) begin
        for (int i = 1; i < FWD_DEPTH; i++) begin
          r_slot_v[i]  <= r_slot_v[i-1];
          r_slot_rd[i] <= r_slot_rd[i-1];
        end
        // Loads never forward from the history; their result arrives later.
        r_slot_v[0]  <= w_issue && i_d_wr_rd && !i_d_is_load && (i_d_rd != 5'd0);
        r_slot_rd[0] <= i_d_rd;
      end
      r_pend <= w_pend_nxt;
      case ({w_ld_set, w_ld_clr})
        2'b10:   if (r_ld_cnt < 4'(MAX_LD)) r_ld_cnt <= r_ld_cnt + 4'd1;
        2'b01:   if (r_ld_cnt != 4'd0)      r_ld_cnt <= r_ld_cnt - 4'd1;
        default: r_ld_cnt <= r_ld_cnt;
      endcase
      if (w_ld_bad) r_err <= 1'b1;
      if (w_stall && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign o_issue          = w_issue;
  assign o_stall          = w_stall;
  assign o_rs1_fwd_sel    = w_rs1_sel;
  assign o_rs2_fwd_sel    = w_rs2_sel;
  assign o_ld_outstanding = r_ld_cnt;
  assign o_err            = r_err;
  assign o_stall_cnt      = r_stall_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  localparam int FWD_DEPTH = 3;
  localparam int MAX_LD    = 4;
  localparam int CNT_W     = 6;
  localparam int SEL_W     = $clog2(FWD_DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             d_valid = 1'b0;
  logic [4:0]       d_rs1 = '0, d_rs2 = '0, d_rd = '0;
  logic             d_use_rs1 = 1'b0, d_use_rs2 = 1'b0, d_wr_rd = 1'b0, d_is_load = 1'b0;
  logic             redirect = 1'b0, hold = 1'b0, ld_done = 1'b0;
  logic [4:0]       ld_rd = '0;
  logic             o_issue, o_stall, o_err;
  logic [SEL_W-1:0] o_rs1_fwd_sel, o_rs2_fwd_sel;
  logic [3:0]       o_ld_outstanding;
  logic [CNT_W-1:0] o_stall_cnt;

  int checks = 0;
  int errors = 0;

  hazard_scoreboard #(.FWD_DEPTH(FWD_DEPTH), .MAX_LD(MAX_LD), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_d_valid(d_valid),
    .i_d_rs1(d_rs1), .i_d_rs2(d_rs2), .i_d_rd(d_rd),
    .i_d_use_rs1(d_use_rs1), .i_d_use_rs2(d_use_rs2),
    .i_d_wr_rd(d_wr_rd), .i_d_is_load(d_is_load),
    .i_redirect(redirect), .i_hold(hold),
    .i_ld_done(ld_done), .i_ld_rd(ld_rd),
    .o_issue(o_issue), .o_stall(o_stall),
    .o_rs1_fwd_sel(o_rs1_fwd_sel), .o_rs2_fwd_sel(o_rs2_fwd_sel),
    .o_ld_outstanding(o_ld_outstanding), .o_err(o_err), .o_stall_cnt(o_stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    bit dv; bit [4:0] rs1; bit [4:0] rs2; bit [4:0] rd;
    bit u1; bit u2; bit wr; bit ld; bit redir; bit hold;
    bit lddone; bit [4:0] ldrd; bit rst;
  } in_t;

  typedef struct packed {
    bit chk; bit issue; bit stall; bit [SEL_W-1:0] s1; bit [SEL_W-1:0] s2;
    bit [3:0] cnt; bit err; bit [CNT_W-1:0] sc;
  } exp_t;

  typedef struct packed { bit v; bit [4:0] rd; } slot_t;

  // Reference model: register bitmap, plain integer load count, age-ordered
  // queue of recent writers (front = youngest).
  bit [31:0]        mpend = '0;
  int               mcnt = 0;
  bit               merr = 1'b0;
  bit [CNT_W-1:0]   mstall = '0;
  bit               mknown = 1'b0;
  slot_t            mslot[$];
  exp_t             sb[$];
  in_t              cur;

  function automatic in_t nop();
    in_t x = '0;
    return x;
  endfunction

  function automatic bit [SEL_W-1:0] fsel(bit [4:0] r, bit use_r);
    for (int i = 0; i < FWD_DEPTH; i++)
      if (use_r && r != 0 && mslot[i].v && mslot[i].rd == r) return SEL_W'(i + 1);
    return '0;
  endfunction

  function automatic exp_t model_out(in_t x);
    exp_t e;
    bit hz;
    hz = x.dv && ((x.u1 && x.rs1 != 0 && mpend[x.rs1]) ||
                  (x.u2 && x.rs2 != 0 && mpend[x.rs2]) ||
                  (x.wr && x.rd != 0 && mpend[x.rd]) ||
                  (x.ld && mcnt == MAX_LD));
    e.chk   = mknown;
    e.issue = x.dv && !hz && !x.redir && !x.hold;
    e.stall = hz && !x.redir && !x.hold;
    e.s1    = fsel(x.rs1, x.u1);
    e.s2    = fsel(x.rs2, x.u2);
    e.cnt   = 4'(mcnt);
    e.err   = merr;
    e.sc    = mstall;
    return e;
  endfunction

  function automatic void model_step(in_t x);
    exp_t e;
    bit setv, clrv, bad;
    if (x.rst) begin
      mpend = '0; mcnt = 0; merr = 0; mstall = '0; mknown = 1'b1;
      for (int i = 0; i < FWD_DEPTH; i++) mslot[i] = '0;
      return;
    end
    e = model_out(x);
    if (!x.hold) begin
      slot_t s;
      s.v  = e.issue && x.wr && !x.ld && x.rd != 0;
      s.rd = x.rd;
      mslot.push_front(s);
      void'(mslot.pop_back());
    end
    setv = e.issue && x.ld && x.rd != 0;
    clrv = x.lddone && x.ldrd != 0 && mpend[x.ldrd];
    bad  = x.lddone && x.ldrd != 0 && !mpend[x.ldrd];
    if (clrv) mpend[x.ldrd] = 1'b0;
    if (setv) mpend[x.rd] = 1'b1;
    mcnt = mcnt + int'(setv) - int'(clrv);
    if (bad) merr = 1'b1;
    if (e.stall && mstall != '1) mstall = mstall + 1'b1;
  endfunction

  task automatic cchk(string n, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", n, act, exp, $time);
    end
  endtask

  task automatic apply(in_t x);
    cur = x;
    d_valid = x.dv; d_rs1 = x.rs1; d_rs2 = x.rs2; d_rd = x.rd;
    d_use_rs1 = x.u1; d_use_rs2 = x.u2; d_wr_rd = x.wr; d_is_load = x.ld;
    redirect = x.redir; hold = x.hold; ld_done = x.lddone; ld_rd = x.ldrd; rst = x.rst;
    sb.push_back(model_out(x));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(cur);
    #1;
  endtask

  task automatic step(in_t x);
    apply(x);
    tick();
  endtask

  function automatic in_t rand_in();
    in_t x = '0;
    bit [4:0] pl[$];
    x.dv    = ($urandom_range(0, 9) < 8);
    x.rs1   = 5'($urandom_range(0, 7));
    x.rs2   = 5'($urandom_range(0, 7));
    x.rd    = 5'($urandom_range(0, 7));
    x.u1    = 1'($urandom_range(0, 1));
    x.u2    = 1'($urandom_range(0, 1));
    x.ld    = ($urandom_range(0, 2) == 0);
    x.wr    = x.ld ? ($urandom_range(0, 7) != 0) : 1'($urandom_range(0, 1));
    x.redir = ($urandom_range(0, 9) == 0);
    x.hold  = ($urandom_range(0, 9) == 0);
    x.lddone = ($urandom_range(0, 2) == 0);
    if (x.lddone) begin
      for (int r = 1; r < 32; r++) if (mpend[r]) pl.push_back(5'(r));
      if (pl.size() == 0 || $urandom_range(0, 5) == 0) x.ldrd = 5'($urandom_range(0, 31));
      else x.ldrd = pl[$urandom_range(0, pl.size() - 1)];
    end
    x.rst = ($urandom_range(0, 399) == 0);
    return x;
  endfunction

  // Monitor: one expectation per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.chk) begin
          cchk("issue", o_issue, e.issue);
          cchk("stall", o_stall, e.stall);
          cchk("rs1_fwd_sel", o_rs1_fwd_sel, e.s1);
          cchk("rs2_fwd_sel", o_rs2_fwd_sel, e.s2);
          cchk("ld_outstanding", o_ld_outstanding, e.cnt);
          cchk("err", o_err, e.err);
          cchk("stall_cnt", o_stall_cnt, e.sc);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    in_t x;
    for (int i = 0; i < FWD_DEPTH; i++) mslot.push_back('0);
    @(posedge clk); #1;

    // reset, then idle outputs all zero
    x = nop(); x.rst = 1; step(x); step(x);
    x = nop(); apply(x); #2;
    cchk("rst_issue", o_issue, 0); cchk("rst_stall", o_stall, 0);
    cchk("rst_sel1", o_rs1_fwd_sel, 0); cchk("rst_cnt", o_ld_outstanding, 0);
    cchk("rst_stall_cnt", o_stall_cnt, 0);
    tick();

    // forwarding ages out of the history
    x = nop(); x.dv = 1; x.wr = 1; x.rd = 5; apply(x); #2; cchk("add_issue", o_issue, 1); tick();
    for (int k = 1; k <= FWD_DEPTH + 1; k++) begin
      x = nop(); x.dv = 1; x.u1 = 1; x.rs1 = 5; apply(x); #2;
      cchk("fwd_age", o_rs1_fwd_sel, (k <= FWD_DEPTH) ? k : 0);
      tick();
    end

    // load-use stall released by load return
    x = nop(); x.dv = 1; x.ld = 1; x.wr = 1; x.rd = 7; apply(x); #2; cchk("lw_issue", o_issue, 1); tick();
    for (int k = 1; k <= 3; k++) begin
      x = nop(); x.dv = 1; x.u2 = 1; x.rs2 = 7;
      if (k == 3) begin x.lddone = 1; x.ldrd = 7; end
      apply(x); #2; cchk("lu_stall", o_stall, 1); cchk("lu_noissue", o_issue, 0); tick();
    end
    x = nop(); x.dv = 1; x.u2 = 1; x.rs2 = 7; apply(x); #2;
    cchk("lu_release", o_issue, 1); cchk("lu_stall_cnt", o_stall_cnt, 3);
    cchk("lu_cnt", o_ld_outstanding, 0);
    tick();

    // load queue full
    for (int r = 1; r <= MAX_LD; r++) begin
      x = nop(); x.dv = 1; x.ld = 1; x.wr = 1; x.rd = 5'(r); apply(x); #2; cchk("fill_issue", o_issue, 1); tick();
    end
    x = nop(); x.dv = 1; x.ld = 1; x.wr = 1; x.rd = 6; apply(x); #2;
    cchk("full_stall", o_stall, 1); cchk("full_cnt", o_ld_outstanding, MAX_LD); tick();
    x.lddone = 1; x.ldrd = 1; apply(x); #2; cchk("full_stall2", o_stall, 1); tick();
    x.lddone = 0; x.ldrd = 0; apply(x); #2;
    cchk("full_release", o_issue, 1); cchk("full_cnt2", o_ld_outstanding, MAX_LD - 1); tick();
    for (int r = 2; r <= MAX_LD + 2; r++) begin
      if (r == MAX_LD + 1) continue;
      x = nop(); x.lddone = 1; x.ldrd = 5'(r); step(x);
    end

    // same-register issue and return; spurious return sets sticky err
    x = nop(); x.dv = 1; x.ld = 1; x.wr = 1; x.rd = 9; step(x);
    x = nop(); x.dv = 1; x.ld = 1; x.rd = 9; x.lddone = 1; x.ldrd = 9; apply(x); #2;
    cchk("same_issue", o_issue, 1); tick();
    x = nop(); x.lddone = 1; x.ldrd = 12; apply(x); #2;
    cchk("same_cnt", o_ld_outstanding, 1); cchk("err_before", o_err, 0); tick();
    x = nop(); x.lddone = 1; x.ldrd = 9; apply(x); #2; cchk("err_set", o_err, 1); tick();
    x = nop(); apply(x); #2; cchk("err_sticky", o_err, 1); cchk("same_clear", o_ld_outstanding, 0); tick();

    // redirect squashes, hold freezes history but load return still lands
    x = nop(); x.dv = 1; x.ld = 1; x.wr = 1; x.rd = 3; step(x);
    x = nop(); x.dv = 1; x.wr = 1; x.rd = 4; x.u1 = 1; x.rs1 = 3; x.redir = 1; apply(x); #2;
    cchk("redir_stall", o_stall, 0); cchk("redir_issue", o_issue, 0); tick();
    x = nop(); x.dv = 1; x.u1 = 1; x.rs1 = 4; apply(x); #2; cchk("redir_bubble", o_rs1_fwd_sel, 0); tick();
    x = nop(); x.dv = 1; x.wr = 1; x.rd = 8; step(x);
    x = nop(); x.dv = 1; x.u1 = 1; x.rs1 = 8; x.hold = 1; x.lddone = 1; x.ldrd = 3; apply(x); #2;
    cchk("hold_sel", o_rs1_fwd_sel, 1); cchk("hold_issue", o_issue, 0); tick();
    x.lddone = 0; x.ldrd = 0; apply(x); #2;
    cchk("hold_frozen", o_rs1_fwd_sel, 1); cchk("hold_ld_clr", o_ld_outstanding, 0); tick();
    x.hold = 0; apply(x); #2; cchk("unhold_sel", o_rs1_fwd_sel, 1); cchk("unhold_issue", o_issue, 1); tick();
    apply(x); #2; cchk("unhold_age", o_rs1_fwd_sel, 2); tick();

    // reset mid-operation
    x = nop(); x.dv = 1; x.ld = 1; x.wr = 1; x.rd = 10; step(x);
    x.rd = 11; step(x);
    x = nop(); x.dv = 1; x.u1 = 1; x.rs1 = 10; apply(x); #2;
    cchk("mid_cnt", o_ld_outstanding, 2); cchk("mid_stall", o_stall, 1); tick();
    x.rst = 1; x.lddone = 1; x.ldrd = 10; step(x);
    x = nop(); x.dv = 1; x.u1 = 1; x.rs1 = 10; apply(x); #2;
    cchk("mrst_cnt", o_ld_outstanding, 0); cchk("mrst_err", o_err, 0);
    cchk("mrst_stall_cnt", o_stall_cnt, 0); cchk("mrst_pend", o_issue, 1); cchk("mrst_stall", o_stall, 0);
    tick();

    // randomized traffic
    for (int n = 0; n < 3000; n++) step(rand_in());

    // stall counter saturation
    x = nop(); x.rst = 1; step(x);
    x = nop(); x.dv = 1; x.ld = 1; x.wr = 1; x.rd = 2; step(x);
    x = nop(); x.dv = 1; x.u1 = 1; x.rs1 = 2;
    for (int n = 0; n < (1 << CNT_W) + 6; n++) step(x);
    apply(x); #2; cchk("stall_cnt_sat", o_stall_cnt, (1 << CNT_W) - 1); tick();

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
